// File: rtl/xy2_100_rx.sv
// XY2-100 galvo command receiver: synchronizes SYNC/CLK/X/Y, validates 20-bit frames, and outputs two's-complement setpoints with link health.
// Define XY2_STATUS_EN to build the status-frame serializer on xy_status; otherwise xy_status mirrors link_ok.
module xy2_100_rx #(
  parameter int TIMEOUT = 2000
) (
  input  logic        clk_ref,
  input  logic        reset,
  input  logic        xy_sync,
  input  logic        xy_clk,
  input  logic        xy_x,
  input  logic        xy_y,
  output logic        xy_status,
  output logic [15:0] pos_x,
  output logic [15:0] pos_y,
  output logic        pos_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        link_ok
);

  localparam logic [15:0] TO = 16'(TIMEOUT);

  logic [1:0]  sync_ff, x_ff, y_ff;
  logic [2:0]  clk_ff;
  logic [19:0] sr_x, sr_y;
  logic [4:0]  bit_cnt, eval_cnt;
  logic        eval_pend;
  logic [15:0] wd;
  logic        seen;
  logic        clk_fall, frame_ok, accept, link_ok_d;

  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      sync_ff <= '0;
      x_ff    <= '0;
      y_ff    <= '0;
      clk_ff  <= '0;
    end else begin
      sync_ff <= {sync_ff[0], xy_sync};
      x_ff    <= {x_ff[0], xy_x};
      y_ff    <= {y_ff[0], xy_y};
      clk_ff  <= {clk_ff[1:0], xy_clk};
    end
  end

  // data/sync taken from stage 1 so they line up with clk_ff[1]
  assign clk_fall = clk_ff[2] & ~clk_ff[1];

  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      sr_x      <= '0;
      sr_y      <= '0;
      bit_cnt   <= '0;
      eval_cnt  <= '0;
      eval_pend <= 1'b0;
    end else begin
      eval_pend <= 1'b0;
      if (clk_fall) begin
        sr_x <= {sr_x[18:0], x_ff[1]};
        sr_y <= {sr_y[18:0], y_ff[1]};
        if (sync_ff[1]) begin
          if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
        end else begin
          eval_pend <= 1'b1;
          eval_cnt  <= bit_cnt;
          bit_cnt   <= '0;
        end
      end
    end
  end

  assign frame_ok  = (eval_cnt == 5'd19) &&
                     (sr_x[19:17] == 3'b001) && (sr_y[19:17] == 3'b001) &&
                     !(^sr_x) && !(^sr_y);
  assign accept    = eval_pend && frame_ok;
  assign link_ok_d = seen && (wd < TO);

  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      pos_x     <= '0;
      pos_y     <= '0;
      pos_valid <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
      wd        <= '0;
      seen      <= 1'b0;
      link_ok   <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      frame_err <= 1'b0;
      link_ok   <= link_ok_d;
      if (eval_pend) begin
        if (frame_ok) begin
          pos_x     <= {~sr_x[16], sr_x[15:1]};
          pos_y     <= {~sr_y[16], sr_y[15:1]};
          pos_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end
      // an accept wins over the watchdog reaching its limit in the same cycle
      if (accept) begin
        wd   <= '0;
        seen <= 1'b1;
      end else if (wd < TO) begin
        wd <= wd + 16'd1;
      end
    end
  end

`ifdef XY2_STATUS_EN
  logic [19:0] st_word;
  logic [4:0]  st_left;
  logic        st_load;
  logic        clk_rise;
  logic [15:0] st_data;

  assign clk_rise = ~clk_ff[2] & clk_ff[1];
  assign st_data  = {link_ok_d, 7'b0, err_cnt};

  // latched one cycle after evaluation so link_ok/err_cnt reflect this frame
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      st_word   <= '0;
      st_left   <= '0;
      st_load   <= 1'b0;
      xy_status <= 1'b0;
    end else begin
      st_load <= eval_pend;
      if (st_load) begin
        st_word <= {3'b001, st_data, ^st_data};
        st_left <= 5'd20;
      end else if (clk_rise) begin
        if (st_left != 5'd0) begin
          xy_status <= st_word[19];
          st_word   <= {st_word[18:0], 1'b0};
          st_left   <= st_left - 5'd1;
        end else begin
          xy_status <= 1'b0;
        end
      end
    end
  end
`else
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) xy_status <= 1'b0;
    else       xy_status <= link_ok_d;
  end
`endif

endmodule

// File: tb/tb_xy2_100_rx.sv
// Randomized bench for xy2_100_rx with a frame-level reference model and per-cycle output compare.
module tb_xy2_100_rx;
  localparam int TIMEOUT = 2000;

  logic        clk_ref = 1'b0;
  logic        reset = 1'b1;
  logic        xy_sync = 1'b0, xy_clk = 1'b0, xy_x = 1'b0, xy_y = 1'b0;
  logic        xy_status;
  logic [15:0] pos_x, pos_y;
  logic        pos_valid, frame_err, link_ok;
  logic [7:0]  err_cnt;

  xy2_100_rx #(.TIMEOUT(TIMEOUT)) dut (
    .clk_ref(clk_ref), .reset(reset), .xy_sync(xy_sync), .xy_clk(xy_clk),
    .xy_x(xy_x), .xy_y(xy_y), .xy_status(xy_status), .pos_x(pos_x),
    .pos_y(pos_y), .pos_valid(pos_valid), .frame_err(frame_err),
    .err_cnt(err_cnt), .link_ok(link_ok)
  );

  always #25 clk_ref = ~clk_ref;

  typedef struct {
    int          cyc;
    bit          acc;
    logic [15:0] px;
    logic [15:0] py;
  } ev_t;

  ev_t         evq[$];
  int          n_checks = 0, n_fail = 0, cyc = 0;
  int          last_acc = -1, m_err = 0, pv_seen = 0, fe_seen = 0;
  logic [15:0] m_px = '0, m_py = '0;
`ifdef XY2_STATUS_EN
  logic [19:0] st_samp = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: outputs derived from scheduled frame verdicts and time since last accept
  initial begin : compare
    bit   ev, acc;
    logic lk;
    forever begin
      @(posedge clk_ref);
      cyc++;
      #1;
      if (reset) begin
        evq.delete();
        m_px = '0; m_py = '0; m_err = 0; last_acc = -1;
      end else begin
        lk  = (last_acc >= 0) && (cyc - last_acc <= TIMEOUT);
        ev  = 1'b0;
        acc = 1'b0;
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          ev  = 1'b1;
          acc = evq[0].acc;
          if (acc) begin
            m_px = evq[0].px; m_py = evq[0].py; last_acc = cyc;
          end else if (m_err < 255) begin
            m_err++;
          end
          void'(evq.pop_front());
        end
        if (pos_valid) pv_seen++;
        if (frame_err) fe_seen++;
        chk("pos_valid", 32'(pos_valid), 32'(ev && acc));
        chk("frame_err", 32'(frame_err), 32'(ev && !acc));
        chk("pos_x", 32'(pos_x), 32'(m_px));
        chk("pos_y", 32'(pos_y), 32'(m_py));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        chk("link_ok", 32'(link_ok), 32'(lk));
`ifndef XY2_STATUS_EN
        chk("xy_status", 32'(xy_status), 32'(lk));
`endif
      end
    end
  end

  function automatic logic [19:0] mk(input logic [2:0] c, input logic [15:0] d);
    logic [18:0] b;
    b = {c, d};
    return {b, ^b};
  endfunction

  // one XY2 bit: clock high 5 cycles, low 5 cycles; the last bit of a frame schedules its verdict
  task automatic send_bit(input logic s, input logic bx, input logic by, input bit last, input ev_t e);
    ev_t ee;
    @(negedge clk_ref);
    xy_sync = s; xy_x = bx; xy_y = by; xy_clk = 1'b1;
    repeat (5) @(negedge clk_ref);
    xy_clk = 1'b0;
    if (last) begin
      ee = e;
      ee.cyc = cyc + 4;
      evq.push_back(ee);
    end
`ifdef XY2_STATUS_EN
    st_samp = {st_samp[18:0], xy_status};
`endif
    repeat (4) @(negedge clk_ref);
  endtask

  task automatic send_frame(input logic [19:0] xw, input logic [19:0] yw, input int nhigh);
    ev_t e;
    e.cyc = 0;
    e.acc = (nhigh == 19) && (xw[19:17] == 3'b001) && (yw[19:17] == 3'b001) &&
            (^xw == 1'b0) && (^yw == 1'b0);
    e.px  = xw[16:1] ^ 16'h8000;
    e.py  = yw[16:1] ^ 16'h8000;
    for (int i = 0; i <= nhigh; i++)
      send_bit(i < nhigh, xw[19 - (i % 20)], yw[19 - (i % 20)], i == nhigh, e);
  endtask

  initial begin : drive
    logic [19:0] gx, gy, wx, wy;
    ev_t         dummy;
    int          k;
    dummy = '{cyc: 0, acc: 1'b0, px: 16'h0, py: 16'h0};

    repeat (4) @(negedge clk_ref);
    chk("rst_pos_x", 32'(pos_x), 32'h0);
    chk("rst_pos_y", 32'(pos_y), 32'h0);
    chk("rst_flags", 32'({pos_valid, frame_err, link_ok, xy_status}), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk_ref);

    gx = mk(3'b001, 16'h8000);
    gy = mk(3'b001, 16'h1234);
    send_frame(gx, gy, 19);
    repeat (2) @(negedge clk_ref);
    chk("good_pos_x", 32'(pos_x), 32'h0000);
    chk("good_pos_y", 32'(pos_y), 32'h9234);
    chk("good_link", 32'(link_ok), 32'h1);
    chk("good_err", 32'(err_cnt), 32'h0);
    chk("good_pulses", 32'(pv_seen), 32'h1);

`ifdef XY2_STATUS_EN
    send_frame(gx, gy, 19);
    chk("status_word", 32'(st_samp), 32'h30001);
`endif

    send_frame(gx ^ 20'h1, gy, 19);
    repeat (2) @(negedge clk_ref);
    chk("par_err", 32'(err_cnt), 32'h1);
    chk("par_fe", 32'(fe_seen), 32'h1);
    chk("par_pos_x", 32'(pos_x), 32'h0000);
    chk("par_pos_y", 32'(pos_y), 32'h9234);

    send_frame(gx, gy, 22);
    send_frame(mk(3'b001, 16'h0001), gy, 19);
    repeat (2) @(negedge clk_ref);
    chk("long_err", 32'(err_cnt), 32'h2);
    chk("after_long_x", 32'(pos_x), 32'h8001);

    send_frame(gx, mk(3'b011, 16'h5555), 19);
    repeat (2) @(negedge clk_ref);
    chk("ctrl_err", 32'(err_cnt), 32'h3);
    chk("ctrl_pos_y", 32'(pos_y), 32'h9234);

    for (int n = 0; n < 40; n++) begin
      wx = mk(3'b001, 16'($urandom));
      wy = mk(3'b001, 16'($urandom));
      k  = 19;
      case ($urandom_range(0, 4))
        2: if ($urandom_range(0, 1) == 0) wx[$urandom_range(0, 19)] ^= 1'b1;
           else wy[$urandom_range(0, 19)] ^= 1'b1;
        3: wy = mk(3'($urandom_range(0, 7)), wy[16:1]);
        4: k = $urandom_range(15, 23);
        default: ;
      endcase
      send_frame(wx, wy, k);
    end

    for (int n = 0; n < 300; n++) send_frame(gx, gy, 1);
    repeat (2) @(negedge clk_ref);
    chk("sat_err", 32'(err_cnt), 32'hFF);

    send_frame(mk(3'b001, 16'h7FFF), gy, 19);
    repeat (1999) @(negedge clk_ref);
    chk("wd_link_hi", 32'(link_ok), 32'h1);
    repeat (2) @(negedge clk_ref);
    chk("wd_link_lo", 32'(link_ok), 32'h0);
    chk("wd_hold_x", 32'(pos_x), 32'hFFFF);
    chk("wd_hold_err", 32'(err_cnt), 32'hFF);

    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0, dummy);
    reset = 1'b1;
    #1;
    chk("mid_rst_pos", 32'({pos_x, pos_y}), 32'h0);
    chk("mid_rst_flags", 32'({pos_valid, frame_err, link_ok, xy_status}), 32'h0);
    chk("mid_rst_err", 32'(err_cnt), 32'h0);
    repeat (3) @(negedge clk_ref);
    reset = 1'b0;
    send_frame(gx, gy, 11);
    send_frame(gx, gy, 19);
    repeat (2) @(negedge clk_ref);
    chk("trunc_err", 32'(err_cnt), 32'h1);
    chk("recover_y", 32'(pos_y), 32'h9234);
    repeat (20) @(negedge clk_ref);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
